// File: rtl/main_fsm.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/writeback
// from the opcode and drives datapath selects, write enables and the ALU-op code.
module main_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic               mem_ready,
  output logic               adrsrc,
  output logic               irwrite,
  output logic [1:0]         alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic [1:0]         resultsrc,
  output logic               pcupdate,
  output logic               branch,
  output logic               regwrite,
  output logic               memwrite,
  output logic               illegal,
  output logic [STATE_W-1:0] state_dbg
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t state, state_next;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  assign state_dbg = STATE_W'(state);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_next = FETCH;
    adrsrc     = 1'b0;
    irwrite    = 1'b0;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    resultsrc  = 2'b00;
    pcupdate   = 1'b0;
    branch     = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    illegal    = 1'b0;

    case (state)
      FETCH: begin
        alusrcb    = 2'b10;
        resultsrc  = 2'b10;
        irwrite    = mem_ready;
        pcupdate   = mem_ready;
        state_next = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_I:         state_next = EXECI;
          OP_JAL:       state_next = JAL;
          OP_BEQ:       state_next = BEQ;
          default: begin
            state_next = FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adrsrc     = 1'b1;
        state_next = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        resultsrc  = 2'b01;
        regwrite   = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        // Write strobe stays high for the whole wait so the memory sees a stable request.
        adrsrc     = 1'b1;
        memwrite   = 1'b1;
        state_next = mem_ready ? FETCH : MEMWRITE;
      end
      EXECR: begin
        alusrca    = 2'b10;
        aluop      = 2'b10;
        state_next = ALUWB;
      end
      EXECI: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        aluop      = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        regwrite   = 1'b1;
        state_next = FETCH;
      end
      JAL: begin
        alusrca    = 2'b01;
        alusrcb    = 2'b10;
        pcupdate   = 1'b1;
        state_next = ALUWB;
      end
      BEQ: begin
        alusrca    = 2'b10;
        aluop      = 2'b01;
        branch     = 1'b1;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase

    // Reset overrides the decoded outputs so nothing is enabled mid-reset.
    if (reset) begin
      adrsrc    = 1'b0;
      irwrite   = 1'b0;
      alusrca   = 2'b00;
      alusrcb   = 2'b00;
      aluop     = 2'b00;
      resultsrc = 2'b00;
      pcupdate  = 1'b0;
      branch    = 1'b0;
      regwrite  = 1'b0;
      memwrite  = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: stimulus pushes expected per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_main_fsm;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct packed {
    logic [3:0] st;
    logic       adrsrc;
    logic       irwrite;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] resultsrc;
    logic       pcupdate;
    logic       branch;
    logic       regwrite;
    logic       memwrite;
    logic       illegal;
  } outs_t;

  typedef struct {
    outs_t v;
    string name;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       mem_ready;
  logic       adrsrc, irwrite, pcupdate, branch, regwrite, memwrite, illegal;
  logic [1:0] alusrca, alusrcb, aluop, resultsrc;
  logic [3:0] state_dbg;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  main_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .adrsrc(adrsrc), .irwrite(irwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .resultsrc(resultsrc), .pcupdate(pcupdate), .branch(branch),
    .regwrite(regwrite), .memwrite(memwrite), .illegal(illegal), .state_dbg(state_dbg)
  );

  // Reference output table, written from the state descriptions.
  function automatic outs_t exp_outs(input logic [3:0] st, input logic [6:0] o,
                                     input logic mr, input logic rst);
    outs_t e;
    e    = '0;
    e.st = st;
    if (!rst) begin
      case (st)
        4'd0:  begin e.alusrcb = 2'b10; e.resultsrc = 2'b10; e.irwrite = mr; e.pcupdate = mr; end
        4'd1:  begin
          e.alusrca = 2'b01; e.alusrcb = 2'b01;
          e.illegal = !(o == LW || o == SW || o == RT || o == IT || o == JL || o == BQ);
        end
        4'd2:  begin e.alusrca = 2'b10; e.alusrcb = 2'b01; end
        4'd3:  e.adrsrc = 1'b1;
        4'd4:  begin e.resultsrc = 2'b01; e.regwrite = 1'b1; end
        4'd5:  begin e.adrsrc = 1'b1; e.memwrite = 1'b1; end
        4'd6:  begin e.alusrca = 2'b10; e.aluop = 2'b10; end
        4'd7:  begin e.alusrca = 2'b10; e.alusrcb = 2'b01; e.aluop = 2'b10; end
        4'd8:  e.regwrite = 1'b1;
        4'd9:  begin e.alusrca = 2'b01; e.alusrcb = 2'b10; e.pcupdate = 1'b1; end
        4'd10: begin e.alusrca = 2'b10; e.aluop = 2'b01; e.branch = 1'b1; end
        default: ;
      endcase
    end
    return e;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic step(input logic rst, input logic [6:0] o, input logic mr,
                      input logic [3:0] exp_st, input string name);
    exp_t e;
    reset     = rst;
    op        = o;
    mem_ready = mr;
    e.v    = exp_outs(exp_st, o, mr, rst);
    e.name = name;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t  e;
      outs_t a;
      e = q.pop_front();
      a = '{st: state_dbg, adrsrc: adrsrc, irwrite: irwrite, alusrca: alusrca,
            alusrcb: alusrcb, aluop: aluop, resultsrc: resultsrc, pcupdate: pcupdate,
            branch: branch, regwrite: regwrite, memwrite: memwrite, illegal: illegal};
      n_checks++;
      if (a !== e.v) begin
        n_fail++;
        $display("FAIL %s: got state=%0d outs=%h, expected state=%0d outs=%h",
                 e.name, a.st, a, e.v.st, e.v);
      end
    end
  end

  initial begin
    reset = 1'b1; op = 7'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step(1'b1, 7'b0, 1'b1, 4'd0, "reset_hold");

    // lw, mem always ready; op changes after MEMADR must be ignored
    step(1'b0, LW, 1'b1, 4'd0,  "lw_fetch");
    step(1'b0, LW, 1'b1, 4'd1,  "lw_decode");
    step(1'b0, LW, 1'b1, 4'd2,  "lw_memadr");
    step(1'b0, RT, 1'b1, 4'd3,  "lw_memread");
    step(1'b0, BAD, 1'b1, 4'd4, "lw_memwb");

    // sw with three not-ready cycles in MEMWRITE
    step(1'b0, SW, 1'b1, 4'd0,  "sw_fetch");
    step(1'b0, SW, 1'b1, 4'd1,  "sw_decode");
    step(1'b0, SW, 1'b1, 4'd2,  "sw_memadr");
    step(1'b0, BAD, 1'b0, 4'd5, "sw_wait1");
    step(1'b0, LW, 1'b0, 4'd5,  "sw_wait2");
    step(1'b0, BAD, 1'b0, 4'd5, "sw_wait3");
    step(1'b0, BAD, 1'b1, 4'd5, "sw_ready");

    // FETCH stalls two cycles, then R-type
    step(1'b0, RT, 1'b0, 4'd0, "fetch_stall1");
    step(1'b0, RT, 1'b0, 4'd0, "fetch_stall2");
    step(1'b0, RT, 1'b1, 4'd0, "fetch_ready");
    step(1'b0, RT, 1'b1, 4'd1, "r_decode");
    step(1'b0, RT, 1'b1, 4'd6, "r_execr");
    step(1'b0, RT, 1'b1, 4'd8, "r_aluwb");

    // I-type
    step(1'b0, IT, 1'b1, 4'd0, "i_fetch");
    step(1'b0, IT, 1'b1, 4'd1, "i_decode");
    step(1'b0, IT, 1'b1, 4'd7, "i_execi");
    step(1'b0, IT, 1'b1, 4'd8, "i_aluwb");

    // jal
    step(1'b0, JL, 1'b1, 4'd0, "jal_fetch");
    step(1'b0, JL, 1'b1, 4'd1, "jal_decode");
    step(1'b0, JL, 1'b1, 4'd9, "jal_jal");
    step(1'b0, JL, 1'b1, 4'd8, "jal_aluwb");

    // beq
    step(1'b0, BQ, 1'b1, 4'd0,  "beq_fetch");
    step(1'b0, BQ, 1'b1, 4'd1,  "beq_decode");
    step(1'b0, BQ, 1'b1, 4'd10, "beq_beq");

    // illegal opcode
    step(1'b0, BAD, 1'b1, 4'd0, "ill_fetch");
    step(1'b0, BAD, 1'b1, 4'd1, "ill_decode");

    // lw with one not-ready cycle in MEMREAD
    step(1'b0, LW, 1'b1, 4'd0, "lw2_fetch");
    step(1'b0, LW, 1'b1, 4'd1, "lw2_decode");
    step(1'b0, LW, 1'b1, 4'd2, "lw2_memadr");
    step(1'b0, LW, 1'b0, 4'd3, "lw2_wait");
    step(1'b0, LW, 1'b1, 4'd3, "lw2_ready");
    step(1'b0, LW, 1'b1, 4'd4, "lw2_memwb");

    // reset asserted while waiting in MEMWRITE
    step(1'b0, SW, 1'b1, 4'd0, "rst_fetch");
    step(1'b0, SW, 1'b1, 4'd1, "rst_decode");
    step(1'b0, SW, 1'b1, 4'd2, "rst_memadr");
    step(1'b0, SW, 1'b0, 4'd5, "rst_memwrite");
    step(1'b1, SW, 1'b0, 4'd5, "rst_in_memwrite");
    step(1'b0, SW, 1'b0, 4'd0, "rst_after");

    repeat (5) begin
      if (q.size() != 0) @(negedge clk);
    end
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
